// File: rtl/dawson32_mul_core.sv
// ---------------------------------------------------------------------------
// dawson32_mul_core
// Single-precision (IEEE-754 binary32) multiplier, responder side of the
// Dawson stb/ack operand/result protocol. Operand A and operand B arrive on
// separate strobe/acknowledge channels. The product is computed by a
// multi-cycle FSM and offered on a strobe/acknowledge result channel.
// Denormal inputs are flushed to zero, results never denormalise, every NaN
// result is the QNAN pattern, rounding is round-to-nearest-even.
//
// Ports
//   clk            rising-edge clock
//   rst            synchronous active-high reset
//   input_a        operand A, captured on the A transfer edge
//   input_a_stb    initiator has A valid
//   input_a_ack    core ready for A (state GET_A)
//   input_b        operand B, captured on the B transfer edge
//   input_b_stb    initiator has B valid
//   input_b_ack    core ready for B (state GET_B)
//   output_z       registered product bit pattern
//   output_z_stb   result valid (state PUT_Z)
//   output_z_ack   initiator accepts result
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module dawson32_mul_core #(
  parameter logic [31:0] QNAN = 32'h7FC00000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] input_a,
  input  logic        input_a_stb,
  output logic        input_a_ack,
  input  logic [31:0] input_b,
  input  logic        input_b_stb,
  output logic        input_b_ack,
  output logic [31:0] output_z,
  output logic        output_z_stb,
  input  logic        output_z_ack
);

  localparam int unsigned W_WORD = 32;
  localparam int unsigned W_EXP  = 10;
  localparam int unsigned W_MANT = 24;
  localparam int unsigned W_PROD = 2 * W_MANT;

  // Unbiased exponent markers: all-ones field and all-zeros field
  localparam logic signed [W_EXP-1:0] EXP_SPECIAL = 10'sd128;
  localparam logic signed [W_EXP-1:0] EXP_ZERO    = -10'sd127;
  localparam logic signed [W_EXP-1:0] EXP_MAX     = 10'sd127;
  localparam logic signed [W_EXP-1:0] EXP_MIN     = -10'sd126;
  localparam logic signed [W_EXP-1:0] EXP_BIAS    = 10'sd127;

  typedef enum logic [3:0] {
    GET_A     = 4'd0,
    GET_B     = 4'd1,
    UNPACK    = 4'd2,
    SPECIAL   = 4'd3,
    MULTIPLY  = 4'd4,
    NORMALISE = 4'd5,
    ROUND     = 4'd6,
    PACK      = 4'd7,
    PUT_Z     = 4'd8
  } state_t;

  state_t                   r_state;
  logic [W_WORD-1:0]        r_a;
  logic [W_WORD-1:0]        r_b;
  logic [W_WORD-1:0]        r_z;
  logic                     r_a_s;
  logic                     r_b_s;
  logic                     r_z_s;
  logic signed [W_EXP-1:0]  r_a_e;
  logic signed [W_EXP-1:0]  r_b_e;
  logic signed [W_EXP-1:0]  r_z_e;
  logic [W_MANT-1:0]        r_a_m;
  logic [W_MANT-1:0]        r_b_m;
  logic [W_MANT-1:0]        r_z_m;
  logic [W_PROD-1:0]        r_prod;
  logic                     r_guard;
  logic                     r_round;
  logic                     r_sticky;

  // Operand classification from the unpacked fields
  logic w_a_nan;
  logic w_b_nan;
  logic w_a_inf;
  logic w_b_inf;
  logic w_a_zero;
  logic w_b_zero;
  logic w_sign;

  assign w_a_nan  = (r_a_e == EXP_SPECIAL) && (r_a_m[W_MANT-2:0] != '0);
  assign w_b_nan  = (r_b_e == EXP_SPECIAL) && (r_b_m[W_MANT-2:0] != '0);
  assign w_a_inf  = (r_a_e == EXP_SPECIAL) && (r_a_m[W_MANT-2:0] == '0);
  assign w_b_inf  = (r_b_e == EXP_SPECIAL) && (r_b_m[W_MANT-2:0] == '0);
  // A zero exponent field covers both true zero and denormals (flushed)
  assign w_a_zero = (r_a_e == EXP_ZERO);
  assign w_b_zero = (r_b_e == EXP_ZERO);
  assign w_sign   = r_a_s ^ r_b_s;

  // Rounding increment with room for the mantissa carry-out
  logic [W_MANT:0] w_m_inc;
  logic            w_round_up;

  assign w_m_inc    = {1'b0, r_z_m} + (W_MANT+1)'(1);
  assign w_round_up = r_guard & (r_round | r_sticky | r_z_m[0]);

  // Biased exponent for a normal result; only valid when in range
  logic [7:0] w_exp_biased;

  assign w_exp_biased = 8'(r_z_e + EXP_BIAS);

  // Handshake outputs decoded from the state register only
  assign input_a_ack  = (r_state == GET_A);
  assign input_b_ack  = (r_state == GET_B);
  assign output_z_stb = (r_state == PUT_Z);
  assign output_z     = r_z;

  // Control and datapath sequencer
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= GET_A;
      r_z     <= '0;
    end else begin
      unique case (r_state)
        GET_A: begin
          if (input_a_stb) begin
            r_a     <= input_a;
            r_state <= GET_B;
          end
        end

        GET_B: begin
          if (input_b_stb) begin
            r_b     <= input_b;
            r_state <= UNPACK;
          end
        end

        UNPACK: begin
          r_a_s   <= r_a[31];
          r_b_s   <= r_b[31];
          r_a_e   <= $signed({2'b00, r_a[30:23]}) - EXP_BIAS;
          r_b_e   <= $signed({2'b00, r_b[30:23]}) - EXP_BIAS;
          // Hidden bit only for normal operands
          r_a_m   <= {(r_a[30:23] != 8'd0), r_a[22:0]};
          r_b_m   <= {(r_b[30:23] != 8'd0), r_b[22:0]};
          r_state <= SPECIAL;
        end

        SPECIAL: begin
          if (w_a_nan || w_b_nan) begin
            r_z     <= QNAN;
            r_state <= PUT_Z;
          end else if (w_a_inf || w_b_inf) begin
            // Inf times zero has no meaningful value
            r_z     <= (w_a_zero || w_b_zero) ? QNAN : {w_sign, 8'hFF, 23'd0};
            r_state <= PUT_Z;
          end else if (w_a_zero || w_b_zero) begin
            r_z     <= {w_sign, 31'd0};
            r_state <= PUT_Z;
          end else begin
            r_state <= MULTIPLY;
          end
        end

        MULTIPLY: begin
          r_z_s   <= w_sign;
          r_z_e   <= r_a_e + r_b_e;
          r_prod  <= W_PROD'(r_a_m) * W_PROD'(r_b_m);
          r_state <= NORMALISE;
        end

        NORMALISE: begin
          // Product of two [1,2) mantissas lies in [1,4): at most one shift
          if (r_prod[W_PROD-1]) begin
            r_z_m    <= r_prod[47:24];
            r_guard  <= r_prod[23];
            r_round  <= r_prod[22];
            r_sticky <= |r_prod[21:0];
            r_z_e    <= r_z_e + 10'sd1;
          end else begin
            r_z_m    <= r_prod[46:23];
            r_guard  <= r_prod[22];
            r_round  <= r_prod[21];
            r_sticky <= |r_prod[20:0];
          end
          r_state <= ROUND;
        end

        ROUND: begin
          if (w_round_up) begin
            if (w_m_inc[W_MANT]) begin
              // 1.111..1 rounded up becomes 10.0: renormalise to 1.0
              r_z_m <= {1'b1, (W_MANT-1)'(0)};
              r_z_e <= r_z_e + 10'sd1;
            end else begin
              r_z_m <= w_m_inc[W_MANT-1:0];
            end
          end
          r_state <= PACK;
        end

        PACK: begin
          if (r_z_e > EXP_MAX) begin
            r_z <= {r_z_s, 8'hFF, 23'd0};
          end else if (r_z_e < EXP_MIN) begin
            r_z <= {r_z_s, 31'd0};
          end else begin
            r_z <= {r_z_s, w_exp_biased, r_z_m[W_MANT-2:0]};
          end
          r_state <= PUT_Z;
        end

        PUT_Z: begin
          if (output_z_ack) begin
            r_state <= GET_A;
          end
        end

        default: begin
          r_state <= GET_A;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dawson32_mul_core.sv
`timescale 1ns/1ps
module tb_dawson32_mul_core;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] input_a;
  logic        input_a_stb;
  logic        input_a_ack;
  logic [31:0] input_b;
  logic        input_b_stb;
  logic        input_b_ack;
  logic [31:0] output_z;
  logic        output_z_stb;
  logic        output_z_ack;

  always #5 clk = ~clk;

  dawson32_mul_core #(.QNAN(32'h7FC00000)) dut (
    .clk          (clk),
    .rst          (rst),
    .input_a      (input_a),
    .input_a_stb  (input_a_stb),
    .input_a_ack  (input_a_ack),
    .input_b      (input_b),
    .input_b_stb  (input_b_stb),
    .input_b_ack  (input_b_ack),
    .output_z     (output_z),
    .output_z_stb (output_z_stb),
    .output_z_ack (output_z_ack)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] z;
    int          lat;
    int          ack_delay;
  } vec_t;

  localparam int NV = 18;
  vec_t        vecs [NV];
  logic [31:0] sb_q [$];
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Drive one full operation; expected result enters the scoreboard at stimulus time
  task automatic run_op(input string tag, input vec_t v);
    int          lat;
    int          waited;
    logic [31:0] exp_z;
    sb_q.push_back(v.z);
    input_a     = v.a;
    input_a_stb = 1'b1;
    waited = 0;
    while (!input_a_ack && waited < 50) begin
      tick();
      waited++;
    end
    check({tag, "_a_ack"}, 32'(input_a_ack), 32'd1);
    tick();
    input_a_stb = 1'b0;
    input_b     = v.b;
    input_b_stb = 1'b1;
    check({tag, "_b_ack"}, 32'(input_b_ack), 32'd1);
    tick();
    input_b_stb = 1'b0;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (output_z_stb) begin
        lat = k;
        break;
      end
    end
    check({tag, "_latency"}, 32'(lat), 32'(v.lat));
    if (lat != 0) begin
      exp_z = sb_q.pop_front();
      check({tag, "_z"}, output_z, exp_z);
      for (int k = 0; k < v.ack_delay; k++) begin
        input_a     = 32'hDEADBEEF;
        input_a_stb = 1'b1;
        tick();
        check({tag, "_hold_stb"}, 32'(output_z_stb), 32'd1);
        check({tag, "_hold_z"}, output_z, exp_z);
        check({tag, "_hold_a_ack"}, 32'(input_a_ack), 32'd0);
      end
      input_a_stb  = 1'b0;
      output_z_ack = 1'b1;
      tick();
      output_z_ack = 1'b0;
      check({tag, "_stb_drop"}, 32'(output_z_stb), 32'd0);
      check({tag, "_a_ack_back"}, 32'(input_a_ack), 32'd1);
      check({tag, "_z_kept"}, output_z, exp_z);
    end else begin
      void'(sb_q.pop_front());
    end
  endtask

  initial begin
    int stb_seen;
    vecs[0]  = '{32'h3F9D70A4, 32'h4091EB85, 32'h40B37B4A, 6, 0};
    vecs[1]  = '{32'h44F6AF68, 32'h4610099B, 32'h4B8ACBEC, 6, 0};
    vecs[2]  = '{32'h473FF936, 32'hC6DDE29C, 32'hCEA66413, 6, 0};
    vecs[3]  = '{32'h7F800000, 32'h00000000, 32'h7FC00000, 2, 0};
    vecs[4]  = '{32'hFF800000, 32'h40000000, 32'hFF800000, 2, 0};
    vecs[5]  = '{32'h00000001, 32'h3F800000, 32'h00000000, 2, 0};
    vecs[6]  = '{32'h7FC00001, 32'h3F800000, 32'h7FC00000, 2, 0};
    vecs[7]  = '{32'h00000000, 32'h7F800000, 32'h7FC00000, 2, 0};
    vecs[8]  = '{32'h80000000, 32'h3F800000, 32'h80000000, 2, 0};
    vecs[9]  = '{32'h3F800000, 32'h7FC00001, 32'h7FC00000, 2, 0};
    vecs[10] = '{32'h7F000000, 32'h7F000000, 32'h7F800000, 6, 0};
    vecs[11] = '{32'h00800000, 32'h00800000, 32'h00000000, 6, 0};
    vecs[12] = '{32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE, 6, 0};
    vecs[13] = '{32'h40000000, 32'h40400000, 32'h40C00000, 6, 0};
    vecs[14] = '{32'hBFC00000, 32'h40000000, 32'hC0400000, 6, 0};
    vecs[15] = '{32'h3F800001, 32'h3FC00000, 32'h3FC00002, 6, 0};
    vecs[16] = '{32'h3F800003, 32'h3FC00000, 32'h3FC00004, 6, 0};
    vecs[17] = '{32'hFF7FFFFF, 32'h40000000, 32'hFF800000, 6, 0};

    rst          = 1'b1;
    input_a      = 32'h0;
    input_a_stb  = 1'b0;
    input_b      = 32'h0;
    input_b_stb  = 1'b0;
    output_z_ack = 1'b0;
    @(negedge clk);
    tick();
    rst = 1'b0;
    check("rst_z", output_z, 32'h0);
    check("rst_a_ack", 32'(input_a_ack), 32'd1);
    check("rst_b_ack", 32'(input_b_ack), 32'd0);
    check("rst_z_stb", 32'(output_z_stb), 32'd0);

    // A stray B strobe while waiting for A must be ignored
    input_b     = 32'h12345678;
    input_b_stb = 1'b1;
    tick();
    tick();
    check("stray_b_ack", 32'(input_b_ack), 32'd0);
    check("stray_a_ack", 32'(input_a_ack), 32'd1);
    input_b_stb = 1'b0;

    for (int i = 0; i < NV; i++) begin
      run_op($sformatf("v%0d", i), vecs[i]);
    end

    // Backpressure: result held 5 cycles while A is strobed
    run_op("bp", '{32'h40000000, 32'h40400000, 32'h40C00000, 6, 5});

    // Reset while in MULTIPLY discards the operation
    input_a     = 32'h3F9D70A4;
    input_a_stb = 1'b1;
    tick();
    input_a_stb = 1'b0;
    input_b     = 32'h4091EB85;
    input_b_stb = 1'b1;
    tick();
    input_b_stb = 1'b0;
    tick();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_a_ack", 32'(input_a_ack), 32'd1);
    check("midrst_z", output_z, 32'h0);
    stb_seen = 0;
    for (int k = 0; k < 12; k++) begin
      if (output_z_stb) stb_seen++;
      tick();
    end
    check("midrst_no_stb", 32'(stb_seen), 32'd0);
    run_op("post_rst", vecs[0]);

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
